// File: rtl/sram_like_arbiter.sv
// N-channel sram-like request arbiter onto one shared downstream bus.
// One transaction outstanding; optional kseg0/kseg1 address folding.
module sram_like_arbiter #(
   parameter int NCH      = 2,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int ARB_MODE = 0,
   parameter int KSEG_MAP = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH-1:0]    ch_wr,
   input  logic [NCH*DW/8-1:0] ch_wstrb,
   input  logic [NCH*AW-1:0] ch_addr,
   input  logic [NCH*DW-1:0] ch_wdata,
   output logic [NCH-1:0]    ch_addr_ok,
   output logic [NCH-1:0]    ch_data_ok,
   output logic [DW-1:0]     ch_rdata,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [DW/8-1:0]   bus_wstrb,
   output logic [AW-1:0]     bus_addr,
   output logic [DW-1:0]     bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DW-1:0]     bus_rdata,
   output logic              busy
);

   localparam int SW = DW / 8;
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t state, state_nxt;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   logic          win_vld;
   logic          accept;
   logic          done;

   logic          lat_wr;
   logic [SW-1:0] lat_wstrb;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic [AW-1:0] sel_addr;
   logic [AW-1:0] map_addr;

   // Cyclic search starting at rr_ptr; fixed mode starts at 0.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ARB_MODE == 1)
            idx = PW'((int'(rr_ptr) + k) % NCH);
         else
            idx = PW'(k);
         if (!win_vld && ch_req[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   assign sel_addr = ch_addr[win*AW +: AW];

   // kseg0/kseg1 fold: clear the top three bits.
   always_comb begin
      map_addr = sel_addr;
      if (KSEG_MAP != 0 && sel_addr[AW-1 -: 2] == 2'b10)
         map_addr = sel_addr & ~{3'b111, {(AW-3){1'b0}}};
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_vld) begin
               accept    = 1'b1;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (bus_addr_ok) begin
               if (bus_data_ok) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (bus_data_ok) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr    <= '0;
         grant     <= '0;
         lat_wr    <= 1'b0;
         lat_wstrb <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         grant     <= win;
         lat_wr    <= ch_wr[win];
         lat_wstrb <= ch_wstrb[win*SW +: SW];
         lat_addr  <= map_addr;
         lat_wdata <= ch_wdata[win*DW +: DW];
         if (ARB_MODE == 1)
            rr_ptr <= (win == PW'(NCH-1)) ? '0 : win + 1'b1;
      end
   end

   assign ch_addr_ok = (state == IDLE && win_vld)
                     ? NCH'(1) << win : '0;
   assign ch_data_ok = done ? NCH'(1) << grant : '0;
   assign ch_rdata   = bus_rdata;

   assign bus_req   = (state == ADDR);
   assign bus_wr    = lat_wr;
   assign bus_wstrb = lat_wstrb;
   assign bus_addr  = lat_addr;
   assign bus_wdata = lat_wdata;
   assign busy      = (state != IDLE);

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised successor to the CPU top's fixed single-cycle inst/data SRAM ports.
- Accepts NCH independent sram-like request channels (req/addr_ok/data_ok handshake) from the core and arbitrates them onto one shared downstream sram-like bus, one transaction outstanding at a time.
- Optionally applies the kseg0/kseg1 virtual-to-physical mapping.
- Sits between the pipeline's fetch/mem stages and the memory bridge or cache.

Parameters:
- NCH, 2, number of upstream channels (ch0 = inst, ch1 = data by convention); 1..8
- AW, 32, address width
- DW, 32, data width; DW/8 strobe bits
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- KSEG_MAP, 1, 1 = map 0x80000000–0xBFFFFFFF to {3'b000, addr[28:0]}; requires AW == 32

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- ch_req  in  NCH  per-channel request
- ch_wr  in  NCH  1 = write
- ch_wstrb  in  NCH*DW/8  byte strobes; channel i occupies slice i
- ch_addr  in  NCH*AW  addresses, sliced per channel
- ch_wdata  in  NCH*DW  write data, sliced per channel
- ch_addr_ok  out  NCH  request accepted (one-hot or zero)
- ch_data_ok  out  NCH  transaction complete (one-hot or zero)
- ch_rdata  out  DW  read data, valid with ch_data_ok
- bus_req  out  1  downstream request
- bus_wr  out  1  downstream write
- bus_wstrb  out  DW/8  downstream strobes
- bus_addr  out  AW  downstream (mapped) address
- bus_wdata  out  DW  downstream write data
- bus_addr_ok  in  1  downstream accepted request
- bus_data_ok  in  1  downstream completion
- bus_rdata  in  DW  downstream read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, RR pointer = 0, grant register = 0, latched fields = 0.
  - All outputs 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Winner g is selected combinationally among channels with ch_req = 1.
    - ARB_MODE 0: lowest index wins.
    - ARB_MODE 1: first requesting index at or above the RR pointer, searching cyclically.
  - ch_addr_ok[g] = 1 in the same cycle.
  - On that edge: latch wr, wstrb, mapped addr, wdata and g; go to ADDR.
  - ARB_MODE 1: pointer = (g+1) mod NCH on that edge.
  - No request: stay in IDLE; all ch_addr_ok = 0.
- ADDR:
  - bus_req = 1; bus_* driven from the latched registers and held stable until bus_addr_ok.
  - bus_addr_ok = 1, bus_data_ok = 0: go to DATA.
  - bus_addr_ok = 1, bus_data_ok = 1 in the same cycle: ch_data_ok[g] = 1, ch_rdata = bus_rdata; go to IDLE.
- DATA:
  - bus_req = 0.
  - bus_data_ok = 1: ch_data_ok[g] = 1 and ch_rdata = bus_rdata, combinational pass-through; go to IDLE.
  - Writes also complete via data_ok.
- Latency:
  - Request to accept: 0 cycles.
  - Minimum request to data_ok: 1 cycle (ADDR with simultaneous addr_ok/data_ok).
  - Back-to-back: a new request can be accepted in the IDLE cycle immediately after completion.
- ch_rdata = bus_rdata when no ch_data_ok is high; consumers must qualify it with ch_data_ok.
- bus_data_ok outside DATA (and outside ADDR with addr_ok) is ignored.
- ch_addr_ok is never asserted outside IDLE. A requesting channel keeps ch_req high and waits; no request is dropped.
- KSEG_MAP:
  - addr[31:30] == 2'b10: mapped addr = {3'b000, addr[28:0]}.
  - Otherwise the address passes unchanged.
  - Mapping is applied at latch time.
- Reset mid-transaction: the transaction is abandoned and no data_ok is issued. The downstream side is required to be reset together.

Test Plan:
- Reset then idle: resetn low for 3 cycles with ch_req = 0 -> all outputs 0, busy = 0; asynchronous assertion clears a busy state without waiting for a clock edge.
- Single read:
  - Stimulus: ch0 read 0xBFC00000; bus_addr_ok 2 cycles after bus_req; bus_data_ok 3 cycles later with rdata 0x3C1D0010.
  - Response: ch_addr_ok[0] in the request cycle; bus_addr = 0x1FC00000; ch_data_ok[0] pulses once with ch_rdata = 0x3C1D0010; busy drops the next cycle.
- Fixed priority, ARB_MODE 0:
  - Stimulus: ch0 and ch1 request every cycle; downstream completes in 2 cycles.
  - Response: ch0 is granted every time; ch1 never gets ch_addr_ok while ch0 keeps requesting.
- Round-robin, ARB_MODE 1, NCH = 3:
  - Stimulus: all three channels request continuously.
  - Response: grant order 0,1,2,0,1,2; each grant yields exactly one data_ok to the matching channel.
- Write with same-cycle addr_ok/data_ok:
  - Stimulus: ch1 write addr 0x00001000, wdata 0xDEADBEEF, wstrb 0xF; bus asserts addr_ok and data_ok together.
  - Response: bus_wr = 1, bus_wdata = 0xDEADBEEF, bus_addr unmapped; ch_data_ok[1] in that same cycle; back to IDLE with no DATA cycle.
- Reset mid-DATA:
  - Stimulus: assert resetn low while in DATA, then raise bus_data_ok after release.
  - Response: no ch_data_ok is issued; state = IDLE; the stray bus_data_ok is ignored.
